sbox_lane_arbiter: RTL and testbench

Shares one 32-bit S-box lane (four `s_box` instances, one per byte) between two requesters: the round datapath's SubBytes over the full 128-bit state, and the key expansion's SubWord over one 32-bit word. A SubBytes job takes four lane cycles. SubWord requests are single-cycle transfers that interleave with those lane cycles under round-robin arbitration. The block sits between the round controller and the key-schedule unit, so the design needs 4 S-boxes instead of 20.

---
 rtl/sbox_lane_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sbox_lane_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_lane_arbiter.sv
// sbox_lane_arbiter: one 32-bit AES S-box lane shared between a 4-cycle
// SubBytes job over the 128-bit state and single-cycle SubWord transfers
// from the key schedule, with round-robin arbitration while a job runs.

// s_box: AES forward S-box for one byte. The multiplicative inverse is
// x^254 in GF(2^8), which maps 0 to 0. The affine transform follows it.
module s_box (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x4, w_x8, w_x16, w_x32, w_x64, w_x128, w_inv;

    // Inverse by repeated squaring, then the affine transform.
    always_comb begin
        w_x2   = gf_mul(i_byte, i_byte);
        w_x4   = gf_mul(w_x2, w_x2);
        w_x8   = gf_mul(w_x4, w_x4);
        w_x16  = gf_mul(w_x8, w_x8);
        w_x32  = gf_mul(w_x16, w_x16);
        w_x64  = gf_mul(w_x32, w_x32);
        w_x128 = gf_mul(w_x64, w_x64);
        w_inv  = gf_mul(gf_mul(gf_mul(w_x128, w_x64), gf_mul(w_x32, w_x16)),
                        gf_mul(gf_mul(w_x8, w_x4), w_x2));
        o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

module sbox_lane_arbiter #(
    parameter bit INIT_PRIO_SW = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_sb_start,
    input  logic [127:0] i_sb_state_in,
    output logic         o_sb_busy,
    output logic         o_sb_done,
    output logic [127:0] o_sb_state_out,
    input  logic         i_sw_valid,
    input  logic [31:0]  i_sw_word_in,
    output logic         o_sw_ready,
    output logic         o_sw_out_valid,
    output logic [31:0]  o_sw_word_out
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t       r_state, w_state_nxt;
    logic [1:0]   r_widx;
    logic         r_prio_sw;
    logic [127:0] r_work;
    logic [127:0] r_sb_out;
    logic         r_sb_done;
    logic [31:0]  r_sw_out;
    logic         r_sw_ov;

    logic         w_sw_grant, w_sb_grant, w_sb_accept, w_sb_last;
    logic [31:0]  w_work_word, w_lane_in, w_lane_out;
    logic [127:0] w_work_upd;

    // Lane ownership: SubWord always wins in IDLE; in RUN it wins only when
    // the pointer favours it. SubBytes takes every other RUN cycle.
    always_comb begin
        w_sw_grant  = !i_reset && i_sw_valid && ((r_state == S_IDLE) || r_prio_sw);
        w_sb_grant  = (r_state == S_RUN) && !w_sw_grant;
        w_sb_accept = (r_state == S_IDLE) && i_sb_start;
        w_sb_last   = w_sb_grant && (r_widx == 2'd3);
    end

    // Pick the working word for this lane cycle; word 0 is the top 32 bits.
    always_comb begin
        w_work_word = r_work[127:96];
        case (r_widx)
            2'd0: w_work_word = r_work[127:96];
            2'd1: w_work_word = r_work[95:64];
            2'd2: w_work_word = r_work[63:32];
            2'd3: w_work_word = r_work[31:0];
            default: w_work_word = r_work[127:96];
        endcase
    end

    assign w_lane_in = w_sw_grant ? i_sw_word_in : w_work_word;

    // One S-box per lane byte.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        s_box u_sbox (
            .i_byte(w_lane_in[g*8 +: 8]),
            .o_byte(w_lane_out[g*8 +: 8])
        );
    end

    // Working register with the current word replaced by its substitution.
    always_comb begin
        w_work_upd = r_work;
        case (r_widx)
            2'd0: w_work_upd[127:96] = w_lane_out;
            2'd1: w_work_upd[95:64]  = w_lane_out;
            2'd2: w_work_upd[63:32]  = w_lane_out;
            2'd3: w_work_upd[31:0]   = w_lane_out;
            default: w_work_upd = r_work;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state: a start is taken only from IDLE; the last word ends the job.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_sb_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_sb_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, priority pointer and result registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_widx    <= 2'd0;
            r_prio_sw <= INIT_PRIO_SW;
            r_work    <= '0;
            r_sb_out  <= '0;
            r_sb_done <= 1'b0;
            r_sw_out  <= '0;
            r_sw_ov   <= 1'b0;
        end else begin
            r_sb_done <= 1'b0;
            r_sw_ov   <= w_sw_grant;
            if (w_sw_grant) r_sw_out <= w_lane_out;
            // Pointer only moves on RUN grants, where some grant always happens.
            if (r_state == S_RUN) r_prio_sw <= !w_sw_grant;
            if (w_sb_accept) begin
                r_work <= i_sb_state_in;
                r_widx <= 2'd0;
            end
            if (w_sb_grant) begin
                r_work <= w_work_upd;
                r_widx <= r_widx + 2'd1;
                if (w_sb_last) begin
                    r_sb_out  <= w_work_upd;
                    r_sb_done <= 1'b1;
                end
            end
        end
    end

    assign o_sb_busy      = (r_state == S_RUN);
    assign o_sb_done      = r_sb_done;
    assign o_sb_state_out = r_sb_out;
    assign o_sw_ready     = w_sw_grant;
    assign o_sw_out_valid = r_sw_ov;
    assign o_sw_word_out  = r_sw_out;
endmodule

// File: tb/tb_sbox_lane_arbiter.sv
// Bench for sbox_lane_arbiter: directed scenarios with known AES vectors,
// then randomized traffic against a transaction-level reference model.
module tb_sbox_lane_arbiter;
    logic         clk = 1'b0;
    logic         rst, sb_start, sw_valid;
    logic [127:0] sb_in;
    logic [31:0]  sw_in;
    logic         sb_busy, sb_done, sw_ready, sw_ov;
    logic [127:0] sb_out;
    logic [31:0]  sw_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    always #5 clk = ~clk;

    sbox_lane_arbiter #(.INIT_PRIO_SW(1'b1)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_sb_start(sb_start), .i_sb_state_in(sb_in),
        .o_sb_busy(sb_busy), .o_sb_done(sb_done), .o_sb_state_out(sb_out),
        .i_sw_valid(sw_valid), .i_sw_word_in(sw_in),
        .o_sw_ready(sw_ready), .o_sw_out_valid(sw_ov), .o_sw_word_out(sw_out)
    );

    // Reference S-box built from exp/log tables of generator 3.
    logic [7:0] sbox_tbl [0:255];

    function automatic int rotl8(input int b, input int k);
        return ((b << k) | (b >> (8 - k))) & 255;
    endfunction

    task automatic build_tbl;
        int ex [0:254];
        int lg [0:255];
        int p, inv;
        p = 1;
        for (int i = 0; i < 255; i++) begin
            ex[i] = p;
            lg[p] = i;
            p = p ^ (((p << 1) ^ (((p & 128) != 0) ? 283 : 0)) & 255);
        end
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 0 : ex[(255 - lg[x]) % 255];
            sbox_tbl[x] = 8'(inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 99);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = sbox_tbl[w[i*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_tbl[s[i*8 +: 8]];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; sb_start = 1'b1; sb_in = FIPS_IN; sw_valid = 1'b1; sw_in = 32'hcf4f3c09;
        tick; tick; #1;
        n_checks++; if (sw_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", sw_ready); end
        n_checks++; if (sb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", sb_busy); end
        n_checks++; if (sb_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", sb_done); end
        n_checks++; if (sw_ov !== 1'b0) begin n_fail++; $display("FAIL reset_ov got=%b exp=0", sw_ov); end
        n_checks++; if (sb_out !== 128'h0) begin n_fail++; $display("FAIL reset_sbout got=%h exp=0", sb_out); end
        n_checks++; if (sw_out !== 32'h0) begin n_fail++; $display("FAIL reset_swout got=%h exp=0", sw_out); end
        rst = 1'b0; sb_start = 1'b0; sw_valid = 1'b0;
        tick;
        n_checks++; if (sb_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b exp=0", sb_busy); end
    endtask

    task automatic test_fips_subbytes;
        sb_start = 1'b1; sb_in = FIPS_IN;
        tick;
        sb_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_checks++; if (sb_busy !== 1'b1 || sb_done !== 1'b0) begin
                n_fail++; $display("FAIL fips_run c=%0d busy=%b done=%b exp busy=1 done=0", c, sb_busy, sb_done); end
            tick;
        end
        n_checks++; if (sb_done !== 1'b1 || sb_busy !== 1'b0) begin
            n_fail++; $display("FAIL fips_done done=%b busy=%b exp done=1 busy=0", sb_done, sb_busy); end
        n_checks++; if (sb_out !== FIPS_OUT) begin n_fail++; $display("FAIL fips_out got=%h exp=%h", sb_out, FIPS_OUT); end
        tick;
        n_checks++; if (sb_done !== 1'b0 || sb_out !== FIPS_OUT) begin
            n_fail++; $display("FAIL fips_hold done=%b out=%h exp done=0 out=%h", sb_done, sb_out, FIPS_OUT); end
    endtask

    task automatic test_subword;
        sw_valid = 1'b1; sw_in = 32'hcf4f3c09;
        #1;
        n_checks++; if (sw_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready got=%b exp=1", sw_ready); end
        tick;
        sw_valid = 1'b0;
        n_checks++; if (sw_ov !== 1'b1 || sw_out !== 32'h8a84eb01) begin
            n_fail++; $display("FAIL sw_result ov=%b out=%h exp ov=1 out=8a84eb01", sw_ov, sw_out); end
        tick;
        n_checks++; if (sw_ov !== 1'b0 || sw_out !== 32'h8a84eb01) begin
            n_fail++; $display("FAIL sw_hold ov=%b out=%h exp ov=0 out=8a84eb01", sw_ov, sw_out); end
    endtask

    // Continuous SubWord traffic: grants alternate starting with SubWord.
    task automatic test_contention;
        sb_start = 1'b1; sb_in = FIPS_IN; sw_valid = 1'b1; sw_in = 32'h0;
        #1;
        n_checks++; if (sw_ready !== 1'b1) begin n_fail++; $display("FAIL cont_ready c=0 got=%b exp=1", sw_ready); end
        tick;
        sb_start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_checks++; if (sw_ready !== 1'((c % 2) == 1)) begin
                n_fail++; $display("FAIL cont_ready c=%0d got=%b exp=%0d", c, sw_ready, (c % 2)); end
            n_checks++; if (sb_busy !== 1'b1 || sb_done !== 1'b0) begin
                n_fail++; $display("FAIL cont_busy c=%0d busy=%b done=%b", c, sb_busy, sb_done); end
            n_checks++; if (sw_ov !== 1'(c == 1 || (c % 2) == 0)) begin
                n_fail++; $display("FAIL cont_ov c=%0d got=%b", c, sw_ov); end
            if (sw_ov === 1'b1) begin
                n_checks++; if (sw_out !== 32'h63636363) begin
                    n_fail++; $display("FAIL cont_swout c=%0d got=%h exp=63636363", c, sw_out); end
            end
            tick;
        end
        n_checks++; if (sb_done !== 1'b1 || sb_busy !== 1'b0 || sb_out !== FIPS_OUT) begin
            n_fail++; $display("FAIL cont_done done=%b busy=%b out=%h exp 1 0 %h", sb_done, sb_busy, sb_out, FIPS_OUT); end
        n_checks++; if (sw_ready !== 1'b1 || sw_ov !== 1'b0) begin
            n_fail++; $display("FAIL cont_c9 ready=%b ov=%b exp ready=1 ov=0", sw_ready, sw_ov); end
        sw_valid = 1'b0;
        tick;
    endtask

    task automatic test_restart_chain;
        logic [127:0] b;
        b = 128'h00112233445566778899aabbccddeeff;
        sb_start = 1'b1; sb_in = FIPS_IN;
        tick;                                   // c1
        sb_start = 1'b0;
        tick;                                   // c2: illegal restart
        sb_start = 1'b1; sb_in = 128'h0;
        tick;                                   // c3
        sb_start = 1'b0;
        n_checks++; if (sb_busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got=%b exp=1", sb_busy); end
        tick; tick;                             // c5
        n_checks++; if (sb_done !== 1'b1 || sb_out !== FIPS_OUT) begin
            n_fail++; $display("FAIL restart_done done=%b out=%h exp 1 %h", sb_done, sb_out, FIPS_OUT); end
        sb_start = 1'b1; sb_in = b;
        tick;                                   // c6
        sb_start = 1'b0;
        n_checks++; if (sb_busy !== 1'b1 || sb_done !== 1'b0) begin
            n_fail++; $display("FAIL chain_start busy=%b done=%b exp 1 0", sb_busy, sb_done); end
        tick; tick; tick;                       // c9
        n_checks++; if (sb_busy !== 1'b1 || sb_out !== FIPS_OUT) begin
            n_fail++; $display("FAIL chain_hold busy=%b out=%h exp 1 %h", sb_busy, sb_out, FIPS_OUT); end
        tick;                                   // c10
        n_checks++; if (sb_done !== 1'b1 || sb_busy !== 1'b0 || sb_out !== sub_state(b)) begin
            n_fail++; $display("FAIL chain_done done=%b busy=%b out=%h exp 1 0 %h", sb_done, sb_busy, sb_out, sub_state(b)); end
        tick;
    endtask

    task automatic test_reset_midjob;
        sb_start = 1'b1; sb_in = FIPS_IN;
        tick;                                   // c1: SubWord grant moves the pointer
        sb_start = 1'b0; sw_valid = 1'b1; sw_in = 32'h0;
        #1;
        n_checks++; if (sw_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%b exp=1", sw_ready); end
        tick;                                   // c2: reset
        sw_valid = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (sb_busy !== 1'b0 || sb_done !== 1'b0 || sb_out !== 128'h0 || sw_out !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset busy=%b done=%b sbout=%h swout=%h exp 0", sb_busy, sb_done, sb_out, sw_out); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (sb_done !== 1'b0 || sb_busy !== 1'b0) begin
                n_fail++; $display("FAIL mid_nodone i=%0d done=%b busy=%b", i, sb_done, sb_busy); end
            tick;
        end
        sb_start = 1'b1; sb_in = FIPS_IN; sw_valid = 1'b1; sw_in = 32'h0;
        tick;                                   // c1 of fresh job
        sb_start = 1'b0;
        n_checks++; if (sw_ready !== 1'b1) begin n_fail++; $display("FAIL mid_prio got=%b exp=1", sw_ready); end
        for (int c = 1; c < 9; c++) tick;
        n_checks++; if (sb_done !== 1'b1 || sb_out !== FIPS_OUT) begin
            n_fail++; $display("FAIL mid_fresh done=%b out=%h exp 1 %h", sb_done, sb_out, FIPS_OUT); end
        sw_valid = 1'b0;
        tick;
    endtask

    // Random traffic vs. a transaction model: a job needs four SubBytes
    // grants; SubWord wins whenever idle or when it is owed the turn.
    task automatic test_random;
        bit m_busy, m_prio_sw, hold, exp_rdy;
        int m_words;
        logic [127:0] m_job, e_sbo;
        logic [31:0] e_swo;
        logic e_done, e_ov;
        rst = 1'b1; sb_start = 1'b0; sw_valid = 1'b0;
        tick;
        rst = 1'b0;
        m_busy = 0; m_prio_sw = 1; m_words = 0; m_job = '0;
        e_done = 0; e_ov = 0; e_sbo = '0; e_swo = '0; hold = 0;
        for (int c = 0; c < 800; c++) begin
            n_checks++; if (sb_busy !== m_busy || sb_done !== e_done || sb_out !== e_sbo) begin
                n_fail++; $display("FAIL rnd_sb c=%0d busy=%b done=%b out=%h exp %b %b %h", c, sb_busy, sb_done, sb_out, m_busy, e_done, e_sbo); end
            n_checks++; if (sw_ov !== e_ov || sw_out !== e_swo) begin
                n_fail++; $display("FAIL rnd_sw c=%0d ov=%b out=%h exp %b %h", c, sw_ov, sw_out, e_ov, e_swo); end
            rst = ($urandom_range(0, 99) == 0);
            sb_start = ($urandom_range(0, 3) == 0);
            sb_in = {$urandom, $urandom, $urandom, $urandom};
            if (!hold) begin
                sw_valid = 1'($urandom_range(0, 1));
                sw_in = $urandom;
            end
            #1;
            exp_rdy = !rst && sw_valid && (!m_busy || m_prio_sw);
            n_checks++; if (sw_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, sw_ready, exp_rdy); end
            hold = sw_valid && !exp_rdy;
            if (rst) begin
                m_busy = 0; m_prio_sw = 1; e_done = 0; e_ov = 0; e_sbo = '0; e_swo = '0;
            end else begin
                e_ov = exp_rdy;
                if (exp_rdy) e_swo = sub_word(sw_in);
                e_done = 0;
                if (m_busy) begin
                    m_prio_sw = !exp_rdy;
                    if (!exp_rdy) begin
                        m_words--;
                        if (m_words == 0) begin
                            m_busy = 0; e_done = 1; e_sbo = sub_state(m_job);
                        end
                    end
                end else if (sb_start) begin
                    m_busy = 1; m_words = 4; m_job = sb_in;
                end
            end
            tick;
        end
        rst = 1'b0; sb_start = 1'b0; sw_valid = 1'b0;
        tick;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        build_tbl();
        test_reset();
        test_fips_subbytes();
        test_subword();
        test_contention();
        test_restart_chain();
        test_reset_midjob();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
